// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction-fetch front end with registered output, one-entry skid and execute redirect
module fetch_stage #(
  parameter int PC_WIDTH = 32,
  parameter int IWIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                fs_i_clk,
  input  logic                fs_i_rst_n,
  input  logic                fs_i_change_pc,
  input  logic [PC_WIDTH-1:0] fs_i_alu_pc,
  input  logic                fs_i_stall,
  output logic                fs_o_imem_req,
  output logic [PC_WIDTH-1:0] fs_o_imem_addr,
  input  logic                fs_i_imem_ack,
  input  logic [IWIDTH-1:0]   fs_i_imem_rdata,
  output logic                fs_o_ce,
  output logic [PC_WIDTH-1:0] fs_o_pc,
  output logic [PC_WIDTH-1:0] fs_o_pc_plus4,
  output logic [IWIDTH-1:0]   fs_o_instr
);
  typedef enum logic [1:0] {S_RESET, S_FETCH, S_DRAIN} state_t;
  localparam logic [PC_WIDTH-1:0] START_PC = RESET_PC & ~PC_WIDTH'(3);
  state_t state, state_nx;
  logic [PC_WIDTH-1:0] pc_reg, drain_addr, out_pc, skid_pc, target;
  logic [IWIDTH-1:0] out_instr, skid_instr;
  logic out_valid, skid_valid, take, consume;
  assign target = fs_i_alu_pc & ~PC_WIDTH'(3);
  always_ff @(posedge fs_i_clk or negedge fs_i_rst_n)
    if (!fs_i_rst_n) state <= S_RESET;
    else state <= state_nx;
  // A redirect that catches an unacknowledged request must wait out its ack
  always_comb begin
    state_nx = state == S_RESET ? S_FETCH :
               state == S_DRAIN ? (fs_i_imem_ack ? S_FETCH : S_DRAIN) :
               (fs_i_change_pc && fs_o_imem_req && !fs_i_imem_ack ? S_DRAIN : S_FETCH);
  end
  always_comb begin
    fs_o_imem_req = (state == S_FETCH && !skid_valid) || state == S_DRAIN;
    fs_o_imem_addr = state == S_DRAIN ? drain_addr : pc_reg;
  end
  assign take = state == S_FETCH && fs_o_imem_req && fs_i_imem_ack && !fs_i_change_pc;
  assign consume = out_valid && !fs_i_stall;
  always_ff @(posedge fs_i_clk or negedge fs_i_rst_n)
    if (!fs_i_rst_n) begin
      pc_reg <= START_PC;
      drain_addr <= START_PC;
      out_valid <= 1'b0;
      out_pc <= '0;
      out_instr <= '0;
      skid_valid <= 1'b0;
      skid_pc <= '0;
      skid_instr <= '0;
    end else begin
      if (state == S_FETCH && fs_i_change_pc && fs_o_imem_req && !fs_i_imem_ack) drain_addr <= pc_reg;
      if (fs_i_change_pc) begin
        pc_reg <= target;
        out_valid <= 1'b0;
        skid_valid <= 1'b0;
      end else begin
        if (take) pc_reg <= pc_reg + PC_WIDTH'(4);
        // Skid full implies no request, so a skid refill never collides with a new ack
        if (consume && skid_valid) begin
          out_valid <= 1'b1;
          out_pc <= skid_pc;
          out_instr <= skid_instr;
          skid_valid <= 1'b0;
        end else if (take && (consume || !out_valid)) begin
          out_valid <= 1'b1;
          out_pc <= pc_reg;
          out_instr <= fs_i_imem_rdata;
        end else if (take) begin
          skid_valid <= 1'b1;
          skid_pc <= pc_reg;
          skid_instr <= fs_i_imem_rdata;
        end else if (consume) begin
          out_valid <= 1'b0;
        end
      end
    end
  assign fs_o_ce = out_valid;
  assign fs_o_pc = out_pc;
  assign fs_o_pc_plus4 = out_pc + PC_WIDTH'(4);
  assign fs_o_instr = out_valid ? out_instr : '0;
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch front end of the MIPS pipeline. It owns the architectural PC and issues one instruction-memory request at a time. It presents fetched instructions to decode through a registered output with a one-entry skid buffer. It is the consuming end of the execute-stage redirect interface: a `change_pc`/target pair from execute flushes every younger instruction and restarts fetch at the target.

## Interface
Parameters:
- PC_WIDTH, 32, width of PC and instruction-memory address
- IWIDTH, 32, instruction width
- RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
- fs_i_clk  in  1  clock; all state updates on rising edge
- fs_i_rst_n  in  1  reset, asynchronous, active-low
- fs_i_change_pc  in  1  redirect request from execute (single-cycle pulse or held)
- fs_i_alu_pc  in  PC_WIDTH  redirect target; valid when fs_i_change_pc=1
- fs_i_stall  in  1  decode cannot accept; output held while 1
- fs_o_imem_req  out  1  memory request valid
- fs_o_imem_addr  out  PC_WIDTH  request address, word aligned
- fs_i_imem_ack  in  1  request accepted and data returned this cycle
- fs_i_imem_rdata  in  IWIDTH  instruction; valid with ack
- fs_o_ce  out  1  output instruction valid
- fs_o_pc  out  PC_WIDTH  PC of output instruction
- fs_o_pc_plus4  out  PC_WIDTH  fs_o_pc + 4
- fs_o_instr  out  IWIDTH  output instruction

## Operation
- State machine:
  - S_RESET: one cycle, no request.
  - S_FETCH: normal operation.
  - S_DRAIN: a redirect hit an unacknowledged request. Wait for its ack and discard the data.
- Transitions:
  - S_RESET→S_FETCH unconditionally.
  - S_FETCH→S_DRAIN on redirect while req=1 and ack=0.
  - S_DRAIN→S_FETCH on ack.
- Request rule:
  - fs_o_imem_req = state∈{S_FETCH, S_DRAIN} and (state==S_DRAIN or skid empty).
  - addr = pc_reg in S_FETCH; addr = the outstanding address in S_DRAIN.
  - Once asserted, req and addr stay stable until ack. A request is never withdrawn.
- Accepted ack in S_FETCH without redirect:
  - Entry {pc_reg, rdata} goes to the output register if the output is empty or is consumed this cycle. Otherwise it goes to the skid buffer.
  - pc_reg ← pc_reg + 4, mod 2^PC_WIDTH (wraps at all-ones).
- Consumption: the output is consumed when fs_o_ce=1 and fs_i_stall=0. If the skid is full, the skid entry moves to the output in the same edge.
- Redirect (fs_i_change_pc=1), in any state:
  - Output valid, skid valid and any same-cycle ack data are cleared or discarded.
  - pc_reg ← {fs_i_alu_pc[PC_WIDTH-1:2], 2'b00}.
  - Redirect overrides fs_i_stall.
- Redirect during S_DRAIN: target is updated (last one wins); stay in S_DRAIN.
- Redirect in the same cycle as ack in S_FETCH: data is discarded; state stays S_FETCH; the next request goes to the target.
- fs_o_pc_plus4 is derived from the registered fs_o_pc. fs_o_instr is 0 (NOP) whenever fs_o_ce=0.

## Timing
- Reset values:
  - fs_o_ce=0, fs_o_pc=0, fs_o_pc_plus4=4, fs_o_instr=0
  - fs_o_imem_req=0, fs_o_imem_addr=RESET_PC
  - pc_reg=RESET_PC, skid empty, state=S_RESET
- Reset asserted mid-transaction: all state clears immediately and req drops asynchronously. The memory must abandon the outstanding request.
- Start-up: reset released before edge 0. S_FETCH after edge 0, req=1 in cycle 1. With a same-cycle ack, fs_o_ce=1 with fs_o_pc=RESET_PC after edge 1.
- Throughput: one instruction per cycle when ack is combinational and there is no stall. Fetch-to-output latency is 1 cycle after ack.
- Redirect at edge N: fs_o_ce=0 after edge N. The target is requested in cycle N+1 if no request is pending. If S_DRAIN is entered, the target is requested the cycle after the drained ack.
- Stall: outputs are held bit-exact. At most one further ack is absorbed by the skid. While the skid is full, req stays 0 unless in S_DRAIN.

## Test plan
- Reset release, ack tied high → fs_o_pc sequence 0x0, 0x4, 0x8 on consecutive cycles; fs_o_instr matches the memory image.
- Ack delayed 3 cycles per request → req and addr stable for 3 cycles; one output every 4 cycles; no duplicates.
- fs_i_stall high for 4 cycles during streaming → output held at its PC. One extra instruction lands in the skid. After release, the PCs continue with no gap and no loss.
- Redirect to 0x100 while a request to 0x20 is pending with ack 2 cycles later → S_DRAIN. The data for 0x20 never appears; next fs_o_pc=0x100.
- Redirect to 0x40 in the same cycle as ack and stall, with the skid full → output and skid flushed; next valid PC=0x40. Target 0x43 → fetch at 0x40.
- Reset asserted while a request is pending → req and fs_o_ce drop immediately. After release, fetch restarts at RESET_PC.
